inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised, decoupled instruction-fetch front end for the pipelined core.
- Issues sequential fetch requests to instruction memory with up to MAX_OUTSTANDING requests in flight, and buffers responses in a DEPTH-entry FIFO.
- Presents {inst, pc, pc_plus_4} to the ID stage over a valid/ready handshake.
- Handles redirects (branch/trap/xRET) by flushing the queue and discarding stale in-flight responses.

Parameters:
- DATA_SIZE, 32, address/PC width (32 or 64).
- DEPTH, 4, queue entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum un-responded memory requests; 1..DEPTH.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- redirect_en  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  DATA_SIZE  new fetch PC; bit[1:0] forced to 0 internally
- inst_mem_req_valid  out  1  fetch request valid
- inst_mem_req_ready  in  1  memory accepts request
- inst_mem_addr  out  DATA_SIZE  fetch address
- inst_mem_rsp_valid  in  1  response valid; in-order, one per accepted request
- inst_mem_rsp_data  in  32  fetched instruction
- out_valid  out  1  entry available to ID
- out_ready  in  1  ID consumes entry (~stall_id && ~mem_busy)
- out_inst  out  32  instruction at queue head
- out_pc  out  DATA_SIZE  PC of head instruction
- out_pc_plus_4  out  DATA_SIZE  out_pc + 4
- count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (reset=0, async):
  - queue empty; count=0; out_valid=0.
  - inst_mem_req_valid=0.
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - outstanding=0, discard=0.
  - Outputs are valid from the first rising clock edge after release.
- Request issue:
  - inst_mem_req_valid = ~redirect_en && (outstanding < MAX_OUTSTANDING) && (count + outstanding - discard < DEPTH).
  - Slot is reserved at issue, so the FIFO never overflows.
  - inst_mem_addr = fetch_pc.
  - On req_valid && req_ready: fetch_pc += 4 (wraps modulo 2^DATA_SIZE); outstanding += 1.
- Response:
  - Every rsp_valid decrements outstanding.
  - If discard > 0: discard -= 1; data dropped.
  - Otherwise push {rsp_data, rsp_pc}; rsp_pc += 4.
  - rsp_valid while outstanding==0 is ignored; no state change.
- Output:
  - out_valid = (count != 0); head fields come straight from the registered entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged; correct at both full and empty.
  - Pointers wrap at DEPTH.
- Redirect (highest priority, takes effect at the clock edge where redirect_en=1):
  - queue emptied (count=0, pointers reset); fetch_pc=rsp_pc=redirect_pc.
  - discard <= outstanding - rsp_valid_this_cycle, i.e. all remaining in-flight responses become stale, including already-discarding ones.
  - Response and pop in the redirect cycle are dropped.
  - No request is issued in the redirect cycle.
  - First new request is issued the next cycle if credit allows.
- Latency (bypass off):
  - request accept → response arrival: memory dependent.
  - response arrival → out_valid: 1 cycle.
  - redirect → first new request: 1 cycle.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty, discard==0, rsp_valid=1 and no redirect, out_valid is asserted combinationally.
  - out_inst=rsp_data, out_pc=rsp_pc in that same cycle.
  - If out_ready=1 the entry is not written into the queue; if out_ready=0 it is pushed normally.
- Undefined: no combinational path from inst_mem_rsp_* to out_*; response → out_valid latency is 1 cycle.

Test Plan:
- Reset release with RESET_PC=0x100, memory always ready, 1-cycle response, out_ready=1 → requests at 0x100, 0x104, 0x108…; out_pc sequence 0x100, 0x104, …; out_pc_plus_4=out_pc+4; count never exceeds 1.
- out_ready=0, memory always ready (DEPTH=4, MAX_OUTSTANDING=2) → exactly 4 requests issued, count reaches 4, req_valid held 0 afterwards. Raise out_ready → entries 0x100..0x10C drain in order, then fetch resumes at 0x110.
- Two requests in flight (0x200, 0x204), redirect_en with redirect_pc=0x400 → both late responses dropped (out_valid stays 0 for them). Next request addr=0x400; first out_pc=0x400.
- Redirect in the same cycle as a response and a pop with count=2 → count=0 next cycle, discard=outstanding-1, no request that cycle, no stale entry ever presented.
- PC wrap: redirect_pc=0xFFFFFFFC (DATA_SIZE=32) → out_pc 0xFFFFFFFC then 0x00000000; out_pc_plus_4 of the first entry = 0x00000000.
- FETCH_QUEUE_BYPASS_EN defined, empty queue, rsp_valid=1 with data 0x00000013, out_ready=1 → out_valid=1 and out_inst=0x00000013 in the same cycle; count stays 0. With the macro undefined → out_valid rises 1 cycle later.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Decoupled instruction-fetch queue: sequential fetch with bounded in-flight requests, DEPTH-entry response FIFO, redirect flush.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a live response straight to the output when the queue is empty.
module inst_fetch_queue #(
    parameter int unsigned          DATA_SIZE       = 32,
    parameter int unsigned          DEPTH           = 4,
    parameter int unsigned          MAX_OUTSTANDING = 2,
    parameter logic [DATA_SIZE-1:0] RESET_PC        = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_en,
    input  logic [DATA_SIZE-1:0]   redirect_pc,
    output logic                   inst_mem_req_valid,
    input  logic                   inst_mem_req_ready,
    output logic [DATA_SIZE-1:0]   inst_mem_addr,
    input  logic                   inst_mem_rsp_valid,
    input  logic [31:0]            inst_mem_rsp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [DATA_SIZE-1:0]   out_pc,
    output logic [DATA_SIZE-1:0]   out_pc_plus_4,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = CW + OW;
    localparam logic [DATA_SIZE-1:0] PC_STEP = DATA_SIZE'(32'd4);

    logic [DATA_SIZE-1:0] fetch_pc_r;
    logic [DATA_SIZE-1:0] rsp_pc_r;
    logic [OW-1:0]        outstanding_r;
    logic [OW-1:0]        discard_r;
    logic [CW-1:0]        count_r;
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [31:0]          inst_q_r [DEPTH];
    logic [DATA_SIZE-1:0] pc_q_r   [DEPTH];
    logic [DATA_SIZE-1:0] pc4_q_r  [DEPTH];

    logic [SW-1:0]        live_s;
    logic                 req_valid_s;
    logic                 req_fire_s;
    logic                 rsp_take_s;
    logic                 rsp_drop_s;
    logic                 rsp_keep_s;
    logic                 head_valid_s;
    logic                 bypass_s;
    logic                 push_s;
    logic                 pop_s;
    logic [OW-1:0]        outstanding_nxt_s;
    logic [OW-1:0]        discard_nxt_s;
    logic [CW-1:0]        count_nxt_s;
    logic [DATA_SIZE-1:0] redirect_base_s;

    assign redirect_base_s = {redirect_pc[DATA_SIZE-1:2], 2'b00};
    assign inst_mem_addr   = fetch_pc_r;
    assign inst_mem_req_valid = req_valid_s;
    assign count           = count_r;

    // Request credit: every live (non-stale) in-flight request already owns a queue slot.
    always_comb begin
        live_s = SW'(count_r) + SW'(outstanding_r) - SW'(discard_r);
        if (!reset || redirect_en) begin
            req_valid_s = 1'b0;
        end else begin
            req_valid_s = (outstanding_r < OW'(MAX_OUTSTANDING)) && (live_s < SW'(DEPTH));
        end
        req_fire_s = req_valid_s && inst_mem_req_ready;
    end

    // Response classification; a response with nothing outstanding is spurious and ignored.
    always_comb begin
        rsp_take_s   = inst_mem_rsp_valid && (outstanding_r != {OW{1'b0}});
        rsp_drop_s   = rsp_take_s && (discard_r != {OW{1'b0}});
        rsp_keep_s   = rsp_take_s && (discard_r == {OW{1'b0}}) && !redirect_en;
        head_valid_s = (count_r != {CW{1'b0}});
    end

    // Head presentation to ID.
    always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s = rsp_keep_s && !head_valid_s;
        if (bypass_s) begin
            out_inst      = inst_mem_rsp_data;
            out_pc        = rsp_pc_r;
            out_pc_plus_4 = rsp_pc_r + PC_STEP;
        end else begin
            out_inst      = inst_q_r[rd_ptr_r];
            out_pc        = pc_q_r[rd_ptr_r];
            out_pc_plus_4 = pc4_q_r[rd_ptr_r];
        end
`else
        bypass_s      = 1'b0;
        out_inst      = inst_q_r[rd_ptr_r];
        out_pc        = pc_q_r[rd_ptr_r];
        out_pc_plus_4 = pc4_q_r[rd_ptr_r];
`endif
        out_valid = head_valid_s || bypass_s;
        push_s    = rsp_keep_s && !(bypass_s && out_ready);
        pop_s     = head_valid_s && out_ready && !redirect_en;
    end

    // Next-state for credit counters and occupancy; redirect marks every remaining in-flight response stale.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        discard_nxt_s     = discard_r;
        count_nxt_s       = count_r;
        if (redirect_en) begin
            outstanding_nxt_s = outstanding_r - OW'(rsp_take_s);
            discard_nxt_s     = outstanding_r - OW'(rsp_take_s);
            count_nxt_s       = {CW{1'b0}};
        end else begin
            case ({req_fire_s, rsp_take_s})
                2'b10:   outstanding_nxt_s = outstanding_r + OW'(1'b1);
                2'b01:   outstanding_nxt_s = outstanding_r - OW'(1'b1);
                default: outstanding_nxt_s = outstanding_r;
            endcase
            if (rsp_drop_s) begin
                discard_nxt_s = discard_r - OW'(1'b1);
            end else begin
                discard_nxt_s = discard_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1'b1);
                2'b01:   count_nxt_s = count_r - CW'(1'b1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state: PCs, counters and pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {OW{1'b0}};
            discard_r     <= {OW{1'b0}};
            count_r       <= {CW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
            count_r       <= count_nxt_s;
            if (redirect_en) begin
                fetch_pc_r <= redirect_base_s;
                rsp_pc_r   <= redirect_base_s;
                wr_ptr_r   <= {PW{1'b0}};
                rd_ptr_r   <= {PW{1'b0}};
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (rsp_keep_s) begin
                    rsp_pc_r <= rsp_pc_r + PC_STEP;
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1'b1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1'b1);
                end
            end
        end
    end

    // Queue storage; pc_plus_4 is precomputed so the head fields leave straight from registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_q_r[i] <= 32'd0;
                pc_q_r[i]   <= {DATA_SIZE{1'b0}};
                pc4_q_r[i]  <= {DATA_SIZE{1'b0}};
            end
        end else if (push_s) begin
            inst_q_r[wr_ptr_r] <= inst_mem_rsp_data;
            pc_q_r[wr_ptr_r]   <= rsp_pc_r;
            pc4_q_r[wr_ptr_r]  <= rsp_pc_r + PC_STEP;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: memory model with configurable latency, expected-PC queue, negedge monitor.
module tb_inst_fetch_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        inst_mem_req_valid;
    logic        inst_mem_req_ready;
    logic [31:0] inst_mem_addr;
    logic        inst_mem_rsp_valid;
    logic [31:0] inst_mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;
    logic [2:0]  count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          mem_lat = 1;
    int          max_cnt = 0;
    logic [31:0] exp_q   [$];
    logic [31:0] req_log [$];
    logic [31:0] pend_a  [$];
    int          pend_d  [$];
    logic [31:0] mon_e;

    inst_fetch_queue #(
        .DATA_SIZE(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0100)
    ) dut (
        .clock(clock), .reset(reset),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .inst_mem_req_valid(inst_mem_req_valid), .inst_mem_req_ready(inst_mem_req_ready),
        .inst_mem_addr(inst_mem_addr),
        .inst_mem_rsp_valid(inst_mem_rsp_valid), .inst_mem_rsp_data(inst_mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .count(count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11};
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Memory model: in-order responses mem_lat cycles after acceptance.
    initial begin
        inst_mem_rsp_valid = 1'b0;
        inst_mem_rsp_data  = 32'd0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                pend_a.delete();
                pend_d.delete();
            end else if (inst_mem_req_valid && inst_mem_req_ready) begin
                pend_a.push_back(inst_mem_addr);
                pend_d.push_back(cyc + mem_lat);
                req_log.push_back(inst_mem_addr);
            end
            @(posedge clock);
            #1;
            if (reset && pend_a.size() != 0 && pend_d[0] <= cyc) begin
                inst_mem_rsp_valid = 1'b1;
                inst_mem_rsp_data  = mem_word(pend_a.pop_front());
                void'(pend_d.pop_front());
            end else begin
                inst_mem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: every accepted output must match the next expected PC.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready && !redirect_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h, want no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc", out_pc, mon_e);
                check("out_inst", out_inst, mem_word(mon_e));
                check("out_pc_plus_4", out_pc_plus_4, mon_e + 32'd4);
            end
        end
    end

    task automatic do_reset(input logic [31:0] pc, input logic redir, input logic ordy);
        @(posedge clock);
        #1;
        reset = 1'b0;
        redirect_en = redir;
        redirect_pc = pc;
        out_ready = ordy;
        inst_mem_req_ready = 1'b1;
        exp_q.delete();
        req_log.delete();
        @(posedge clock);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(inst_mem_req_valid), 32'd0);
        reset = 1'b1;
        if (redir) begin
            @(posedge clock);
            #1;
            redirect_en = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        max_cnt = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clock);
            #1;
            k++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d entries left, want 0", name, exp_q.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (req_log.size() < n && k < budget) begin
            @(posedge clock);
            #1;
            k++;
        end
        check({name, "_req_seen"}, 32'(req_log.size()), 32'(n));
    endtask

    task automatic wait_count(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (int'(count) != n && k < budget) begin
            @(posedge clock);
            #1;
            k++;
        end
        check({name, "_count_wait"}, 32'(count), 32'(n));
    endtask

    initial begin
        reset = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'd0;
        inst_mem_req_ready = 1'b1;
        out_ready = 1'b0;

        // Streaming from RESET_PC with 1-cycle memory.
        mem_lat = 1;
        do_reset(32'h0, 1'b0, 1'b1);
        push_exp(32'h0000_0100, 8);
        drain("seq", 60);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("seq_max_count", 32'(max_cnt), 32'd0);
`else
        check("seq_max_count", 32'(max_cnt), 32'd1);
`endif
        check("seq_req0", log_at(0), 32'h0000_0100);
        check("seq_req1", log_at(1), 32'h0000_0104);
        check("seq_req2", log_at(2), 32'h0000_0108);

        // Fill with ID stalled, then drain and resume.
        do_reset(32'h0, 1'b0, 1'b0);
        repeat (8) @(posedge clock);
        #1;
        check("fill_count", 32'(count), 32'd4);
        check("fill_req_valid", 32'(inst_mem_req_valid), 32'd0);
        check("fill_req_num", 32'(req_log.size()), 32'd4);
        push_exp(32'h0000_0100, 6);
        out_ready = 1'b1;
        drain("fill", 60);
        check("fill_resume", log_at(4), 32'h0000_0110);

        // Redirect with two requests in flight: both late responses are stale.
        mem_lat = 4;
        do_reset(32'h0000_0200, 1'b1, 1'b1);
        wait_log("inflight", 2, 20);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0400;
        @(negedge clock);
        check("redir_no_req", 32'(inst_mem_req_valid), 32'd0);
        @(posedge clock);
        #1;
        redirect_en = 1'b0;
        check("redir_count", 32'(count), 32'd0);
        push_exp(32'h0000_0400, 3);
        drain("redir", 80);
        check("redir_req0", log_at(0), 32'h0000_0200);
        check("redir_req1", log_at(1), 32'h0000_0204);
        check("redir_req2", log_at(2), 32'h0000_0400);

        // Redirect coinciding with a response and a pop at count=2.
        mem_lat = 1;
        do_reset(32'h0, 1'b0, 1'b0);
        wait_count("rc", 2, 20);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0302;
        out_ready = 1'b1;
        @(negedge clock);
        check("rc_no_req", 32'(inst_mem_req_valid), 32'd0);
        check("rc_head", out_pc, 32'h0000_0100);
        @(posedge clock);
        #1;
        redirect_en = 1'b0;
        check("rc_flush_count", 32'(count), 32'd0);
        check("rc_flush_valid", 32'(out_valid), 32'd0);
        push_exp(32'h0000_0300, 3);
        @(negedge clock);
        check("rc_next_req", 32'(inst_mem_req_valid), 32'd1);
        check("rc_next_addr", inst_mem_addr, 32'h0000_0300);
        drain("rc", 60);
        check("rc_req2", log_at(2), 32'h0000_0108);
        check("rc_req3", log_at(3), 32'h0000_0300);

        // PC wrap at the top of the address space.
        do_reset(32'hFFFF_FFFC, 1'b1, 1'b1);
        push_exp(32'hFFFF_FFFC, 3);
        drain("wrap", 60);
        check("wrap_req1", log_at(1), 32'h0000_0000);

        // Response-to-output latency on an empty queue.
        do_reset(32'h0000_0010, 1'b1, 1'b1);
        push_exp(32'h0000_0010, 3);
        wait_log("lat", 1, 20);
        @(negedge clock);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("lat_valid_same", 32'(out_valid), 32'd1);
        check("lat_inst_same", out_inst, 32'h0000_0013);
        check("lat_count_same", 32'(count), 32'd0);
        @(negedge clock);
        check("lat_count_next", 32'(count), 32'd0);
`else
        check("lat_valid_same", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("lat_valid_next", 32'(out_valid), 32'd1);
        check("lat_inst_next", out_inst, 32'h0000_0013);
`endif
        drain("lat", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end
endmodule
